// File: rtl/dr_word_deser.sv
// Dual-rail word deserializer: rebuilds one single-rail block from WORDS spacer/codeword pairs
// and flags spacer and code faults. Optional error counter: define DR_DESER_ERR_CNT_EN.
module dr_word_deser #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sp_pol,
    input  logic [WORD_W-1:0]        din_1,
    input  logic [WORD_W-1:0]        din_0,
    output logic                     busy,
    output logic [WORD_W*WORDS-1:0]  blk_out,
    output logic                     blk_valid,
    output logic                     err_spacer,
    output logic                     err_code,
    output logic [15:0]              err_cnt
);

    localparam int BLK_W = WORD_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SPACER,
        DATA
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [BLK_W-1:0]   acc;
    logic [BLK_W-1:0]   next_acc;
    logic               spacer_bad;
    logic               code_bad;
    logic               last_word;

    assign spacer_bad = (din_1 != {WORD_W{sp_pol}}) || (din_0 != {WORD_W{sp_pol}});
    assign code_bad   = |(din_1 ~^ din_0);
    assign last_word  = (idx == IDX_W'(WORDS - 1));

    // Word 0 lands in the MSBs; the incoming word is merged so the final word
    // can go straight to blk_out on the completing edge.
    always_comb begin
        next_acc = acc;
        next_acc[BLK_W - 1 - int'(idx) * WORD_W -: WORD_W] = din_1;
    end

    always_ff @(posedge clk) begin
        if (!start && state == DATA) begin
            acc <= next_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            blk_out    <= '0;
            blk_valid  <= 1'b0;
            err_spacer <= 1'b0;
            err_code   <= 1'b0;
            idx        <= '0;
        end else begin
            blk_valid <= 1'b0;
            if (start) begin
                // Also serves as abort: partial words are simply overwritten later.
                state      <= SPACER;
                busy       <= 1'b1;
                idx        <= '0;
                err_spacer <= 1'b0;
                err_code   <= 1'b0;
            end else begin
                case (state)
                    SPACER: begin
                        if (spacer_bad) begin
                            err_spacer <= 1'b1;
                        end
                        state <= DATA;
                    end
                    DATA: begin
                        if (code_bad) begin
                            err_code <= 1'b1;
                        end
                        idx <= idx + 1'b1;
                        if (last_word) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_out   <= next_acc;
                            idx       <= '0;
                        end else begin
                            state <= SPACER;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef DR_DESER_ERR_CNT_EN
    logic        err_hit;
    logic [15:0] cnt;

    assign err_hit = !start && ((state == SPACER && spacer_bad) || (state == DATA && code_bad));

    // Lifetime fault counter: survives starts, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (err_hit && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign err_cnt = cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dr_word_deser.sv
// Scoreboard bench for dr_word_deser: expected blocks are queued when driven
// and compared when blk_valid fires.
module tb_dr_word_deser;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sp_pol;
    logic [31:0]  din_1;
    logic [31:0]  din_0;
    logic         busy;
    logic [127:0] blk_out;
    logic         blk_valid;
    logic         err_spacer;
    logic         err_code;
    logic [15:0]  err_cnt;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    typedef struct packed {
        logic [127:0] blk;
        logic         esp;
        logic         ecode;
    } exp_t;

    exp_t sb[$];

    dr_word_deser #(.WORD_W(32), .WORDS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sp_pol     (sp_pol),
        .din_1      (din_1),
        .din_0      (din_0),
        .busy       (busy),
        .blk_out    (blk_out),
        .blk_valid  (blk_valid),
        .err_spacer (err_spacer),
        .err_code   (err_code),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each completion must match the oldest queued block.
    always @(negedge clk) begin
        if (blk_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("blk_out", blk_out, e.blk);
                check("err_spacer", err_spacer, e.esp);
                check("err_code", err_code, e.ecode);
                check("busy_done", busy, 1'b0);
                check("err_cnt", err_cnt, 128'(exp_cnt));
            end
        end
    end

    task automatic drive_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", busy, 1'b1);
        check("esp_clear", err_spacer, 1'b0);
        check("ecode_clear", err_code, 1'b0);
    endtask

    task automatic drive_spacer(input logic pol, input logic bad);
        if (bad) begin
            sp_pol = 1'b0;
            din_1  = '1;
            din_0  = '1;
`ifdef DR_DESER_ERR_CNT_EN
            exp_cnt++;
`endif
        end else begin
            sp_pol = pol;
            din_1  = {32{pol}};
            din_0  = {32{pol}};
        end
        @(negedge clk);
    endtask

    task automatic drive_word(input logic [31:0] w, input logic bad);
        if (bad) begin
            din_1 = w | 32'h20;
            din_0 = ~w | 32'h20;
`ifdef DR_DESER_ERR_CNT_EN
            exp_cnt++;
`endif
        end else begin
            din_1 = w;
            din_0 = ~w;
        end
        @(negedge clk);
    endtask

    task automatic run_block(input logic [127:0] words, input int sp_bad, input int code_bad);
        exp_t         e;
        logic [127:0] expb;
        expb = words;
        if (code_bad >= 0) begin
            expb[127 - 32 * code_bad -: 32] = expb[127 - 32 * code_bad -: 32] | 32'h20;
        end
        e.blk   = expb;
        e.esp   = (sp_bad >= 0);
        e.ecode = (code_bad >= 0);
        sb.push_back(e);
        drive_start();
        for (int k = 0; k < 4; k++) begin
            drive_spacer(k[0], k == sp_bad);
            drive_word(words[127 - 32 * k -: 32], k == code_bad);
        end
        check("valid_timing", blk_valid, 1'b1);
    endtask

    localparam logic [127:0] CLEAN = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ABCD  = 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        sp_pol = 1'b0;
        din_1  = $urandom;
        din_0  = $urandom;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_blk_out", blk_out, '0);
        check("rst_valid", blk_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_esp", err_spacer, 1'b0);
        check("rst_ecode", err_code, 1'b0);
        check("rst_cnt", err_cnt, '0);
        repeat (2) @(negedge clk);

        run_block(CLEAN, -1, -1);
        @(negedge clk);
        check("valid_one_cycle", blk_valid, 1'b0);
        check("hold_blk", blk_out, CLEAN);

        run_block(CLEAN, -1, 2);
        repeat (3) @(negedge clk);
        check("ecode_sticky", err_code, 1'b1);

        run_block(CLEAN, 1, -1);
        repeat (2) @(negedge clk);
        check("esp_sticky", err_spacer, 1'b1);
        run_block(128'h0123456789abcdeffedcba9876543210, -1, -1);

        // Abort at E5 with garbage partial words, then a full block.
        drive_start();
        drive_spacer(1'b0, 1'b0);
        drive_word(32'h11111111, 1'b0);
        drive_spacer(1'b1, 1'b0);
        drive_word(32'h22222222, 1'b0);
        run_block(ABCD, -1, -1);
        repeat (2) @(negedge clk);

        // Reset sampled at E4.
        drive_start();
        drive_spacer(1'b0, 1'b0);
        drive_word(32'h33333333, 1'b0);
        drive_spacer(1'b1, 1'b0);
        reset = 1'b1;
        din_1 = 32'h44444444;
        din_0 = ~32'h44444444;
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = 0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", blk_valid, 1'b0);
        check("midrst_blk", blk_out, '0);
        check("midrst_cnt", err_cnt, '0);
        repeat (3) @(negedge clk);
        check("midrst_idle_valid", blk_valid, 1'b0);

        run_block(CLEAN, -1, -1);
        repeat (5) @(negedge clk);
        check("sb_empty", 128'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dr_word_deser.md
Name: dr_word_deser

Overview:
- Receives the dual-rail 32-bit output word stream of the dual-rail AES core (core_0dr `data_out_1`/`data_out_0`) and reassembles one 128-bit single-rail block from four codewords.
- Checks the return-to-spacer discipline (alternating all-0/all-1 spacers) and checks codeword validity (the two rails must be complementary).
- Sits between the dual-rail core and single-rail consumers, and doubles as the on-chip result checker for spacer/code faults.

Parameters:
- WORD_W, 32, width of one dual-rail word (per rail).
- WORDS, 4, data words per block; block width = WORD_W*WORDS.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: begin receiving a new block (also aborts a block in progress).
- sp_pol  input  1  expected spacer polarity this cycle (driven from clkdiv2); spacer must equal {WORD_W{sp_pol}} on both rails.
- din_1  input  WORD_W  true rail.
- din_0  input  WORD_W  false rail.
- busy  output  1  high while a block is being received.
- blk_out  output  WORD_W*WORDS  assembled block, first word in MSBs.
- blk_valid  output  1  one-cycle pulse: blk_out updated.
- err_spacer  output  1  sticky: a spacer cycle did not match sp_pol.
- err_code  output  1  sticky: a data cycle had at least one bit with din_1 == din_0.
- err_cnt  output  16  saturating count of erroneous cycles (see Optional Feature).

Behaviour:
- Reset (sync, active-high): state IDLE, busy=0, blk_out=0, blk_valid=0, err_spacer=0, err_code=0, err_cnt=0, word index=0. Reset beats start in the same cycle.
- States: IDLE, SPACER, DATA.
- IDLE, start=1: go to SPACER, clear err_spacer/err_code, word index=0, busy=1. err_cnt is not cleared.
- Edge timing: let E0 be the edge that samples start=1.
  - Spacer is sampled at E1, E3, E5, E7.
  - Data is sampled at E2, E4, E6, E8.
  - Strict alternation; no stalls.
- SPACER: if din_1 != {WORD_W{sp_pol}} or din_0 != {WORD_W{sp_pol}}, set err_spacer. Go to DATA unconditionally.
- DATA: if any bit has din_1[i] == din_0[i], set err_code. Store din_1 into word slot idx (idx 0 -> bits [WORD_W*WORDS-1 -: WORD_W]), then idx++.
  - If idx was WORDS-1: go to IDLE, busy=0, blk_valid=1 for exactly the cycle after E8, and blk_out shows the new block in that same cycle.
  - Otherwise: go to SPACER.
- blk_out holds its value until the next completed block. An aborted block never changes blk_out.
- Errors do not stop reception. blk_valid still pulses, and the error flags are valid in the same cycle as blk_valid.
- Error flags hold until the next accepted start or reset.
- start=1 while busy: abort the current block and restart immediately; that edge becomes the new E0. Errors clear, partial words are discarded, and no blk_valid is issued for the aborted block.
- blk_valid is 0 in every cycle other than the completion cycle.
- din_1/din_0 are ignored in IDLE.
- Reset mid-block: return to IDLE, no blk_valid, blk_out cleared to 0.

Optional Feature:
- Macro DR_DESER_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on every sampled cycle that sets (or would set) err_spacer or err_code. It saturates at 16'hFFFF, is cleared only by reset, and persists across blocks and starts.
- Not defined: err_cnt is a constant 0, no counter register is built, and the port remains present.

Test Plan:
- Reset: assert reset 2 cycles with arbitrary din -> blk_out=0, blk_valid=0, busy=0, err_spacer=0, err_code=0, err_cnt=0.
- Clean block: start at E0. Spacers are 0/1/0/1 with matching sp_pol. din_1 words are 3925841d, 02dc09fb, dc118597, 196a0b32, each with din_0 = ~din_1. Expect: blk_out=3925841d02dc09fbdc118597196a0b32; blk_valid high for exactly one cycle after E8; busy high E0..E8; both error flags 0.
- Code fault: repeat the clean block but with din_0 bit5 = din_1 bit5 = 1 in word 2. Expect: err_code=1 at completion, err_spacer=0, blk_out word 2 = din_1 value, blk_valid still pulses. With DR_DESER_ERR_CNT_EN, err_cnt=1.
- Spacer fault: at E3, drive all-1 spacer while sp_pol=0. Expect: err_spacer=1, err_code=0, block still completes with correct data. A following start clears err_spacer.
- Abort and restart: start again at E5 mid-block, then feed a full block of four words AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD. Expect: exactly one blk_valid, 8 edges after the second start, blk_out=AAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD.
- Reset mid-block: assert reset at E4. Expect: busy=0 next cycle, no blk_valid, blk_out=0; later clean blocks complete normally.
